// File: rtl/stack_pointers_if.sv
// Bus bundle for the dual stack-pointer block: CPU data/strobe inputs plus
// read-back and stack-address outputs. The block itself takes the slave view.
interface stack_pointers_if;
  logic [7:0] d_in;
  logic       n_load_0, n_load_1;
  logic       up_0, up_1, down_0, down_1;
  logic       n_oe_d_0, n_oe_d_1;
  logic       n_oe_ia_0, n_oe_ia_1;
  logic [7:0] d_out;
  logic       d_out_en;
  logic [7:0] ia;
  logic       ia_en;
  logic       err_0, err_1;

  modport master (
    output d_in, n_load_0, n_load_1, up_0, up_1, down_0, down_1,
           n_oe_d_0, n_oe_d_1, n_oe_ia_0, n_oe_ia_1,
    input  d_out, d_out_en, ia, ia_en, err_0, err_1
  );

  modport slave (
    input  d_in, n_load_0, n_load_1, up_0, up_1, down_0, down_1,
           n_oe_d_0, n_oe_d_1, n_oe_ia_0, n_oe_ia_1,
    output d_out, d_out_en, ia, ia_en, err_0, err_1
  );
endinterface

// File: rtl/stack_pointers.sv
// Two independent 8-bit stack pointers driven by synchronised active-low strobes.
// Define STACK_SP_BOUNDS_EN to saturate at 0x00/0xFF with sticky error flags instead of wrapping.
module stack_pointers (
  input  logic             clk,
  input  logic             rst,
  stack_pointers_if.slave  bus
);

  // Strobe bit layout per pointer i: [3i] load, [3i+1] up, [3i+2] down (all active-low).
  logic [5:0] w_strobeRaw;
  logic [5:0] w_release;
  logic [1:0] w_nLoadRaw;

  logic [5:0] r_sync1;
  logic [5:0] r_sync2;
  logic [5:0] r_prev;
  logic [1:0] r_blankCnt;
  logic [7:0] r_sp   [2];
  logic [7:0] r_hold [2];
`ifdef STACK_SP_BOUNDS_EN
  logic [1:0] r_err;
`endif

  assign w_strobeRaw = {bus.down_1, bus.up_1, bus.n_load_1,
                        bus.down_0, bus.up_0, bus.n_load_0};
  assign w_nLoadRaw  = {bus.n_load_1, bus.n_load_0};
  assign w_release   = r_sync2 & ~r_prev;

  // The synchroniser is held idle for two cycles after reset so a strobe that
  // was already low during reset cannot produce a spurious release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_prev     <= '1;
      r_blankCnt <= 2'd2;
      for (int i = 0; i < 2; i++) begin
        r_sp[i]   <= 8'h00;
        r_hold[i] <= 8'h00;
      end
`ifdef STACK_SP_BOUNDS_EN
      r_err <= 2'b00;
`endif
    end else begin
      r_sync1 <= (r_blankCnt != 2'd0) ? '1 : w_strobeRaw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_blankCnt != 2'd0)
        r_blankCnt <= r_blankCnt - 2'd1;

      for (int i = 0; i < 2; i++) begin
        if (!w_nLoadRaw[i])
          r_hold[i] <= bus.d_in;

        if (w_release[3*i]) begin
          r_sp[i] <= r_hold[i];
`ifdef STACK_SP_BOUNDS_EN
          r_err[i] <= 1'b0;
`endif
        end else if (w_release[3*i+1] && !w_release[3*i+2]) begin
`ifdef STACK_SP_BOUNDS_EN
          if (r_sp[i] == 8'hFF)
            r_err[i] <= 1'b1;
          else
            r_sp[i] <= r_sp[i] + 8'd1;
`else
          r_sp[i] <= r_sp[i] + 8'd1;
`endif
        end else if (w_release[3*i+2] && !w_release[3*i+1]) begin
`ifdef STACK_SP_BOUNDS_EN
          if (r_sp[i] == 8'h00)
            r_err[i] <= 1'b1;
          else
            r_sp[i] <= r_sp[i] - 8'd1;
`else
          r_sp[i] <= r_sp[i] - 8'd1;
`endif
        end
      end
    end
  end

  // SP0 wins when both enables of a bus are asserted.
  assign bus.d_out    = !bus.n_oe_d_0  ? r_sp[0] : (!bus.n_oe_d_1  ? r_sp[1] : 8'h00);
  assign bus.d_out_en = ~(bus.n_oe_d_0 & bus.n_oe_d_1);
  assign bus.ia       = !bus.n_oe_ia_0 ? r_sp[0] : (!bus.n_oe_ia_1 ? r_sp[1] : 8'h00);
  assign bus.ia_en    = ~(bus.n_oe_ia_0 & bus.n_oe_ia_1);

`ifdef STACK_SP_BOUNDS_EN
  assign bus.err_0 = r_err[0];
  assign bus.err_1 = r_err[1];
`else
  assign bus.err_0 = 1'b0;
  assign bus.err_1 = 1'b0;
`endif

endmodule

// File: doc/stack_pointers.md
STACK_POINTERS -- requirements
Module: stack_pointers

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port d_in  in  8  CPU data bus, load value.
REQ-004 SHALL have ports n_load_0, n_load_1  in  1 each  load strobe per SP, active-low.
REQ-005 SHALL have ports up_0, up_1, down_0, down_1  in  1 each  count strobes, active-low.
REQ-006 SHALL have ports n_oe_d_0, n_oe_d_1  in  1 each  read-back enable per SP, active-low.
REQ-007 SHALL have ports n_oe_ia_0, n_oe_ia_1  in  1 each  stack-address enable per SP, active-low.
REQ-008 SHALL have ports d_out  out  8  read-back value, and d_out_en  out  1  data-bus drive enable.
REQ-009 SHALL have ports ia  out  8  stack RAM address, and ia_en  out  1  address drive enable.
REQ-010 SHALL have ports err_0, err_1  out  1 each  sticky bound-error flags.

Function
REQ-011 SHALL hold two 8-bit pointers SP0 and SP1, each with identical, independent logic.
REQ-012 SHALL pass each strobe through a 2-flop synchroniser, then through a rising-edge (release) detector; an action fires on the cycle a release is detected.
REQ-013 SHALL make the action effect visible on d_out/ia after the 3rd rising clk edge following strobe release; strobes must be low for at least 2 clk periods.
REQ-014 SHALL copy d_in into a per-SP hold register on every edge where raw n_load_x is low; a load action writes SPx = hold_x.
REQ-015 SHALL, on an up action, set SPx = SPx+1; on a down action, set SPx = SPx-1 (8-bit).
REQ-016 SHALL give priority load > (up xor down); simultaneous up and down releases on the same cycle leave SPx unchanged.
REQ-017 SHALL keep SP0 and SP1 actions in the same cycle fully independent.
REQ-018 SHALL drive d_out = SP0 when n_oe_d_0 low, else SP1 when n_oe_d_1 low, else 0x00; d_out_en = ~(n_oe_d_0 & n_oe_d_1); combinational from registers.
REQ-019 SHALL drive ia = SP0 when n_oe_ia_0 low, else SP1 when n_oe_ia_1 low, else 0x00; ia_en = ~(n_oe_ia_0 & n_oe_ia_1).
REQ-020 SHALL read back the pre-update value on the cycle an action fires (no bypass).
REQ-021 SHALL clear err_x only by reset or by a load action on that SP.

Reset
REQ-022 SHALL, while rst high, force SP0 = SP1 = 0x00, hold registers = 0x00, err_0 = err_1 = 0, all synchroniser/edge flops to the idle (high) state.
REQ-023 SHALL discard any strobe in progress when rst asserts; a strobe released while rst is high, or within 2 cycles after deassertion, SHALL NOT fire.
REQ-024 SHALL have outputs d_out/ia = 0x00 after reset, with enables following the n_oe inputs only.

Configuration
REQ-025 SHALL, with STACK_SP_BOUNDS_EN defined: up at 0xFF and down at 0x00 leave SPx unchanged and set err_x = 1.
REQ-026 SHALL, without STACK_SP_BOUNDS_EN: wrap modulo 256 (0xFF+1 = 0x00, 0x00-1 = 0xFF) and tie err_0 = err_1 = 0.

Verification
REQ-027 SHALL cover: reset, n_load_0 low 3 cycles with d_in = 0x5A, release -> SP0 = 0x5A 3 edges later on d_out with n_oe_d_0 low; SP1 stays 0x00.
REQ-028 SHALL cover: SP1 = 0x10, up_1 pulse x3 then down_1 pulse x1 -> ia = 0x12 with n_oe_ia_1 low.
REQ-029 SHALL cover: up_0 and down_0 released on same clk -> SP0 unchanged; n_load_0 and up_0 released together with d_in = 0x33 -> SP0 = 0x33.
REQ-030 SHALL cover: SP0 = 0xFF, up_0 -> 0x00 and err_0 = 0 without macro; 0xFF and err_0 = 1 with macro, then load 0x01 -> err_0 = 0.
REQ-031 SHALL cover: rst pulsed while n_load_1 low with d_in = 0x77, strobe released 1 cycle after rst deasserts -> SP1 stays 0x00.
REQ-032 SHALL cover: n_oe_d_0 and n_oe_d_1 both low with SP0 = 0x01, SP1 = 0x02 -> d_out = 0x01, d_out_en = 1; both high -> d_out = 0x00, d_out_en = 0.
